shot_scheduler: RTL
===================

// Module: shot_scheduler
// PURPOSE
//  Arbitrates fire requests from two tanks (A = local, B = opponent) onto the single shared bullet engine.
//  Enforces each tank's reload countdown and grants round-robin when both tanks fire together.
//  Sequences the engine with a start/done handshake, then applies the shot's damage to the target's HP.
//  Declares game over and the winner. Sits between mouse/UART input decode and the bullet engine.
// PARAMETERS
//  RELOAD_TICKS   13000000  clk cycles per reload step (200 ms at 65 MHz)
//  RELOAD_STEPS   9         reload value loaded on grant; a tank may fire only at 0
//  HP_INIT        150       HP of each tank after reset
//  DAMAGE         15        HP removed per tank hit
//  TIMEOUT_CYCLES 2**24-1   engine watchdog limit (used only with SHOT_TIMEOUT_EN)
// PORTS
//  clk           in   1  clock
//  rst           in   1  synchronous reset, active-high
//  enable        in   1  game running (gameplay screen selected)
//  fire_a/fire_b in   1  fire request, level, sampled only in IDLE
//  dir_a/dir_b   in   2  barrel direction of each tank: 0 up, 1 down, 2 left, 3 right
//  eng_done      in   1  1-cycle pulse: the bullet engine has finished the shot
//  eng_hit_tank  in   1  valid with eng_done: the bullet struck the opposing tank
//  eng_hit_obst  in   1  valid with eng_done: the bullet struck an obstacle or a screen edge
//  eng_start     out  1  1-cycle pulse: launch a bullet
//  eng_owner     out  1  owner of the current shot, 0 = A, 1 = B
//  eng_dir       out  2  direction of the current shot
//  reload_a/_b   out  4  remaining reload steps, for the HUD
//  hp_a/hp_b     out  8  current HP
//  game_over     out  1  sticky; set when either HP reaches 0
//  winner        out  1  valid while game_over = 1; 0 = A wins, 1 = B wins
//  shot_timeout  out  1  1-cycle pulse: watchdog abort; constant 0 without SHOT_TIMEOUT_EN
// BEHAVIOUR
//  Reset: FSM=IDLE, eng_start=0, eng_owner=0, eng_dir=0, reload_a=reload_b=RELOAD_STEPS,
//   hp_a=hp_b=HP_INIT, game_over=0, winner=0, shot_timeout=0, prescaler=0, rr_last=B.
//  All outputs are registered.
//  Prescaler (24 bit):
//   - counts 0..RELOAD_TICKS-1 while enable=1 and game_over=0; it is a single counter shared by both tanks.
//   - On wrap, each nonzero reload counter decrements by 1 and saturates at 0.
//   - Reload period jitter is therefore at most 1 step.
//  enable=0:
//   - prescaler is cleared and both reloads are forced to RELOAD_STEPS.
//   - No new grants.
//   - A shot already in WAIT still completes and is resolved normally.
//  FSM:
//   - IDLE: a tank is eligible when fire_x=1, reload_x=0, enable=1 and game_over=0.
//     - One eligible tank: grant it.
//     - Both eligible: grant the tank other than rr_last.
//     - Grant: capture owner and dir, set rr_last=owner, load reload_owner=RELOAD_STEPS in the same edge, go to START.
//   - START: eng_start=1 for exactly this cycle -> WAIT.
//     - Latency: fire sampled in cycle N, eng_start high in cycle N+1.
//     - eng_owner and eng_dir stay stable from N+1 until back in IDLE.
//   - WAIT: hold until eng_done=1 -> RESOLVE, latching the hit flags.
//     - eng_done seen in START is accepted as well.
//   - RESOLVE (1 cycle):
//     - eng_hit_tank=1: target HP = 0 if HP <= DAMAGE, else HP - DAMAGE.
//     - Tank hit takes priority when both hit flags are set; an obstacle hit or a miss changes no HP.
//     - New HP = 0: game_over=1, winner=owner, go to OVER; otherwise go to IDLE.
//   - OVER: terminal. Fire is ignored, reloads freeze, HP holds. Only rst leaves OVER.
//  Boundaries:
//   - fire while not IDLE: ignored, not queued.
//   - Requester reload=0 and the other tank's reload wraps in the same cycle: both updates apply.
//   - rst mid-shot: eng_start drops immediately; late eng_done pulses are ignored in IDLE.
//   - HP arithmetic is 8-bit unsigned and never wraps below 0.
// CONFIGURATION
//  SHOT_TIMEOUT_EN defined:
//   - A 24-bit watchdog counts cycles in WAIT.
//   - At TIMEOUT_CYCLES: shot_timeout pulses 1 cycle, FSM returns to IDLE, no HP change.
//   - The owner's reload stays as is (already reloading).
//  SHOT_TIMEOUT_EN undefined: no watchdog; shot_timeout is tied 0 and WAIT waits indefinitely.
// TESTING  (RELOAD_TICKS=4, RELOAD_STEPS=2, HP_INIT=30, DAMAGE=15)
//  1. Release rst with enable=1, hold fire_a=1 -> reload_a 2->1->0 over 8 cycles;
//     eng_start 1 cycle later with eng_owner=0, eng_dir=dir_a; reload_a back to 2.
//  2. fire_a=fire_b=1, both reloads 0, rr_last=B -> A is granted.
//     Return eng_done (miss) -> B is granted next, once its own reload is 0.
//  3. B shot returns eng_done with eng_hit_tank=1 twice -> hp_a 30->15->0, game_over=1, winner=1.
//     Later fire_a and fire_b are ignored.
//  4. eng_done with eng_hit_obst=1 only -> hp unchanged, FSM back to IDLE.
//     Both flags set -> treated as a tank hit (-15).
//  5. enable=0 during WAIT with reload_b=1 -> reloads forced to 2, pending shot still resolves,
//     no grant until enable=1.
//  6. With SHOT_TIMEOUT_EN and TIMEOUT_CYCLES=10: no eng_done -> shot_timeout pulses 10 cycles into WAIT,
//     IDLE, HP unchanged. Without the macro: shot_timeout stays 0 and the FSM stays in WAIT.

Source files
------------

// File: rtl/shot_scheduler.sv
// Shot arbiter for two tanks sharing one bullet engine: reload pacing, round-robin grant,
// engine handshake, damage and game-over. Optional engine watchdog under SHOT_TIMEOUT_EN.
module shot_scheduler #(
   parameter int unsigned RELOAD_TICKS   = 13000000,
   parameter int unsigned RELOAD_STEPS   = 9,
   parameter int unsigned HP_INIT        = 150,
   parameter int unsigned DAMAGE         = 15,
   parameter int unsigned TIMEOUT_CYCLES = 24'hFF_FFFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fire_a,
   input  logic       fire_b,
   input  logic [1:0] dir_a,
   input  logic [1:0] dir_b,
   input  logic       eng_done,
   input  logic       eng_hit_tank,
   input  logic       eng_hit_obst,
   output logic       eng_start,
   output logic       eng_owner,
   output logic [1:0] eng_dir,
   output logic [3:0] reload_a,
   output logic [3:0] reload_b,
   output logic [7:0] hp_a,
   output logic [7:0] hp_b,
   output logic       game_over,
   output logic       winner,
   output logic       shot_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESOLVE, S_OVER} state_t;

   localparam logic [23:0] TICK_LAST   = 24'(RELOAD_TICKS - 1);
   localparam logic [3:0]  RELOAD_INIT = 4'(RELOAD_STEPS);
   localparam logic [7:0]  HP_START    = 8'(HP_INIT);
   localparam logic [7:0]  DMG         = 8'(DAMAGE);

   state_t      state_q, state_d;
   logic [23:0] presc_q, presc_d;
   logic [3:0]  reload_a_q, reload_a_d;
   logic [3:0]  reload_b_q, reload_b_d;
   logic [7:0]  hp_a_q, hp_a_d;
   logic [7:0]  hp_b_q, hp_b_d;
   logic        owner_q, owner_d;
   logic [1:0]  dir_q, dir_d;
   logic        start_q, start_d;
   logic        rr_last_q, rr_last_d;
   logic        hit_tank_q, hit_tank_d;
   logic        game_over_q, game_over_d;
   logic        winner_q, winner_d;

   logic        elig_a, elig_b, grant_b;
   logic [7:0]  target_hp, new_hp;

   // An obstacle hit or edge hit resolves exactly like a miss.
   logic        obst_unused;
   assign obst_unused = eng_hit_obst;

`ifdef SHOT_TIMEOUT_EN
   localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);
   logic [23:0] wdog_q, wdog_d;
   logic        shot_timeout_q, shot_timeout_d;
`else
   logic        timeout_unused;
   assign timeout_unused = ^24'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      reload_a_d  = reload_a_q;
      reload_b_d  = reload_b_q;
      hp_a_d      = hp_a_q;
      hp_b_d      = hp_b_q;
      owner_d     = owner_q;
      dir_d       = dir_q;
      start_d     = 1'b0;
      rr_last_d   = rr_last_q;
      hit_tank_d  = hit_tank_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;
`ifdef SHOT_TIMEOUT_EN
      wdog_d         = '0;
      shot_timeout_d = 1'b0;
`endif

      elig_a    = fire_a && (reload_a_q == '0) && enable && !game_over_q;
      elig_b    = fire_b && (reload_b_q == '0) && enable && !game_over_q;
      grant_b   = elig_b && (!elig_a || !rr_last_q);
      target_hp = owner_q ? hp_a_q : hp_b_q;
      new_hp    = (target_hp <= DMG) ? '0 : target_hp - DMG;

      // Shared reload pacing; frozen once the game is decided.
      if (!game_over_q) begin
         if (!enable) begin
            presc_d    = '0;
            reload_a_d = RELOAD_INIT;
            reload_b_d = RELOAD_INIT;
         end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
            if (reload_a_q != '0) reload_a_d = reload_a_q - 4'd1;
            if (reload_b_q != '0) reload_b_d = reload_b_q - 4'd1;
         end else begin
            presc_d = presc_q + 24'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (elig_a || elig_b) begin
               owner_d   = grant_b;
               dir_d     = grant_b ? dir_b : dir_a;
               rr_last_d = grant_b;
               if (grant_b) reload_b_d = RELOAD_INIT;
               else         reload_a_d = RELOAD_INIT;
               start_d   = 1'b1;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (eng_done) begin
               hit_tank_d = eng_hit_tank;
               state_d    = S_RESOLVE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (eng_done) begin
               hit_tank_d = eng_hit_tank;
               state_d    = S_RESOLVE;
            end
`ifdef SHOT_TIMEOUT_EN
            else if (wdog_q == WDOG_LAST) begin
               shot_timeout_d = 1'b1;
               state_d        = S_IDLE;
            end else begin
               wdog_d = wdog_q + 24'd1;
            end
`endif
         end
         S_RESOLVE: begin
            state_d = S_IDLE;
            if (hit_tank_q) begin
               if (owner_q) hp_a_d = new_hp;
               else         hp_b_d = new_hp;
               if (new_hp == '0) begin
                  game_over_d = 1'b1;
                  winner_d    = owner_q;
                  state_d     = S_OVER;
               end
            end
         end
         S_OVER:  state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         reload_a_q  <= RELOAD_INIT;
         reload_b_q  <= RELOAD_INIT;
         hp_a_q      <= HP_START;
         hp_b_q      <= HP_START;
         owner_q     <= 1'b0;
         dir_q       <= '0;
         start_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         hit_tank_q  <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         reload_a_q  <= reload_a_d;
         reload_b_q  <= reload_b_d;
         hp_a_q      <= hp_a_d;
         hp_b_q      <= hp_b_d;
         owner_q     <= owner_d;
         dir_q       <= dir_d;
         start_q     <= start_d;
         rr_last_q   <= rr_last_d;
         hit_tank_q  <= hit_tank_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

`ifdef SHOT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q         <= '0;
         shot_timeout_q <= 1'b0;
      end else begin
         wdog_q         <= wdog_d;
         shot_timeout_q <= shot_timeout_d;
      end
   end
   assign shot_timeout = shot_timeout_q;
`else
   assign shot_timeout = 1'b0;
`endif

   assign eng_start = start_q;
   assign eng_owner = owner_q;
   assign eng_dir   = dir_q;
   assign reload_a  = reload_a_q;
   assign reload_b  = reload_b_q;
   assign hp_a      = hp_a_q;
   assign hp_b      = hp_b_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;

endmodule
